power_monitor_scanner: RTL
==========================

Name: power_monitor_scanner

Overview:
- Sequences the 3-bit analog voltage-select mux over NUM_CH battery/rail channels.
- For each channel: waits a settle time, then majority-samples the 1-bit comparator line from the power board.
- Produces per-channel status and drives the kill-switch "power" output consumed by global_disable and the UART gating.
- Sits between the power-board header pins and the Avalon power-management slave register file.

Parameters:
- NUM_CH, 8, number of mux channels scanned (2..8).
- MUX_W, 3, mux select width.
- SETTLE_CYCLES, 5000, clk cycles after a mux change before sampling (100 us at 50 MHz).
- SAMPLES, 16, comparator samples per channel (power of two).
- TRIP_SCANS, 3, consecutive failing scans of one channel that trip the kill.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- data_in  in  1  asynchronous comparator bit; 1 = channel voltage OK.
- enable  in  1  scan enable from slave register.
- kill_req  in  1  software kill, level-sensitive.
- clear_fault  in  1  single-cycle pulse; clears latched fault.
- mux  out  MUX_W  analog mux select.
- ch_status  out  NUM_CH  last committed OK bit per channel.
- scan_done  out  1  single-cycle pulse at end of each full scan.
- scan_count  out  16  completed scans; wraps at 0xFFFF->0.
- power  out  1  kill switch; 1 = motors/peripherals powered.
- fault  out  1  sticky under-voltage trip flag.
- fault_ch  out  MUX_W  channel that caused the trip.

Behaviour:
- Reset values: mux=0, ch_status=0, scan_done=0, scan_count=0, power=0, fault=0, fault_ch=0, FSM=IDLE, all counters 0.
- data_in passes through a 2-FF synchronizer. Its 2-cycle latency is absorbed by SETTLE.
- FSM states:
  - IDLE: enter SETTLE when enable=1.
  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: count synchronized ones over exactly SAMPLES cycles, then go to COMMIT.
  - COMMIT: single cycle. OK = ones > SAMPLES/2 (a tie counts as fail). Write ch_status[mux]=OK. The per-channel fail counter increments (saturating at TRIP_SCANS) on fail and clears on OK. mux advances, wrapping NUM_CH-1 -> 0. On wrap, assert scan_done for 1 cycle and increment scan_count. Next state is SETTLE.
- enable=0 in any state: return to IDLE next cycle and discard the partial sample. mux, ch_status, power and fault hold.
- Trip: in the COMMIT where a fail counter reaches TRIP_SCANS:
  - fault<=1, fault_ch<=that channel, power<=0 on the following edge.
  - fault is sticky until clear_fault.
- Arm: power<=1 at a scan wrap only if fault=0, kill_req=0, and all NUM_CH fail counters are 0.
- kill_req=1: power<=0 next cycle regardless of state; fault is not set; scanning continues.
- clear_fault: clears fault, fault_ch and all fail counters. power stays 0 until the next qualifying scan wrap.
- Simultaneous clear_fault and trip in the same cycle: the trip wins.
- Simultaneous kill_req and arm: kill wins.
- Reset asserted mid-scan: all state returns to reset values asynchronously. Scanning restarts at channel 0 after release when enable=1.

Optional Feature:
- POWER_MON_CH_MASK_EN
- Defined: adds input port ch_mask [NUM_CH-1:0]. Masked channels are still scanned and reported in ch_status, but their fail counters are held at 0, so they never trip and never block arming.
- Undefined: port absent; every channel participates.

Decomposition:
- Package pwr_mon_pkg holds:
  - the FSM state enum (IDLE, SETTLE, SAMPLE, COMMIT);
  - counter width constants derived via clog2 of SETTLE_CYCLES, SAMPLES and TRIP_SCANS;
  - the scan_count width (16).
- Sub-module pwr_mon_sample_filter contains the 2-FF synchronizer plus the ones counter and majority compare. Its interface is start/done/ok.

Test Plan:
Bench uses SETTLE_CYCLES=4, SAMPLES=4, TRIP_SCANS=2, NUM_CH=8.
- data_in=1, enable=1 after reset -> mux steps 0..7 then wraps to 0; scan_done pulses once; scan_count=1; ch_status=8'hFF; power=1 on the wrap cycle+1.
- data_in forced 0 only while mux=5, for two scans -> fault=1, fault_ch=5, power=0 after the second scan's COMMIT of ch5; ch_status[5]=0.
- In the same fault state, pulse clear_fault, then data_in=1 -> fault=0; power returns to 1 only after the next full scan wrap.
- Samples 1,1,0,0 on a channel (tie) -> ch_status bit 0. Samples 1,1,1,0 -> ch_status bit 1.
- kill_req=1 for one scan with data_in=1 -> power=0 next cycle; fault stays 0; power=1 at the first wrap after kill_req=0.
- Assert reset mid-SAMPLE on ch3 -> all outputs at reset values immediately. After release, scanning starts at mux=0.
- With POWER_MON_CH_MASK_EN and ch_mask=8'h20, ch5 failing -> no fault; power=1.

Source files
------------

// File: rtl/pwr_mon_pkg.sv
// Shared types and sizing for the power monitor scanner.
//   state_e    : scan FSM states
//   cnt_w()    : bits needed to hold 0..n
//   *_W        : counter widths at the default parameter values
//   SCAN_CNT_W : width of the completed-scan counter
package pwr_mon_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, COMMIT} state_e;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int DEF_SETTLE_CYCLES = 5000;
  localparam int DEF_SAMPLES       = 16;
  localparam int DEF_TRIP_SCANS    = 3;

  localparam int SETTLE_W   = cnt_w(DEF_SETTLE_CYCLES);
  localparam int SAMPLE_W   = cnt_w(DEF_SAMPLES);
  localparam int TRIP_W     = cnt_w(DEF_TRIP_SCANS);
  localparam int SCAN_CNT_W = 16;

endpackage

// File: rtl/pwr_mon_sample_filter.sv
// Comparator conditioning for one channel measurement.
//   clk, reset : clock, async active-high reset
//   data_in    : raw asynchronous comparator bit
//   start      : pulse; the next SAMPLES cycles form the sample window
//   abort      : drops an in-progress window
//   done       : high in the final sample cycle of the window
//   ok         : valid with done; more than half of the samples were 1
module pwr_mon_sample_filter
  import pwr_mon_pkg::*;
#(
  parameter int SAMPLES = DEF_SAMPLES
)(
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  input  logic start,
  input  logic abort,
  output logic done,
  output logic ok
);

  localparam int IW = cnt_w(SAMPLES - 1);
  localparam int OW = cnt_w(SAMPLES);
  localparam logic [IW-1:0] LAST = IW'(SAMPLES - 1);
  localparam logic [OW-1:0] HALF = OW'(SAMPLES / 2);

  logic          sync1, sync2;
  logic          busy;
  logic [IW-1:0] idx;
  logic [OW-1:0] ones, ones_nxt;

  // done/ok are combinational so the caller sees the result in the last
  // sample cycle and the window is exactly SAMPLES cycles long.
  assign ones_nxt = ones + OW'(sync2);
  assign done     = busy && (idx == LAST);
  assign ok       = ones_nxt > HALF;  // tie is a fail

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      busy  <= 1'b0;
      idx   <= '0;
      ones  <= '0;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        busy <= 1'b1;
        idx  <= '0;
        ones <= '0;
      end else if (busy) begin
        ones <= ones_nxt;
        idx  <= idx + 1'b1;
        if (done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/power_monitor_scanner.sv
// Scans the power-board voltage mux, majority-samples each channel's
// comparator and drives the system kill switch.
//   clk, reset    : 50 MHz clock, async active-high reset
//   data_in       : comparator bit, 1 = selected channel OK
//   enable        : scan enable
//   kill_req      : software kill (level)
//   clear_fault   : pulse, clears latched fault and fail counters
//   ch_mask       : (POWER_MON_CH_MASK_EN only) channels excluded from trip/arm
//   mux           : analog mux select
//   ch_status     : last committed OK bit per channel
//   scan_done     : pulse at each full-scan wrap
//   scan_count    : completed scans, wrapping
//   power         : 1 = motors/peripherals powered
//   fault, fault_ch : sticky under-voltage trip and offending channel
// Build option: define POWER_MON_CH_MASK_EN to add the ch_mask port.
module power_monitor_scanner
  import pwr_mon_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int MUX_W         = 3,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLES       = DEF_SAMPLES,
  parameter int TRIP_SCANS    = DEF_TRIP_SCANS
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  enable,
  input  logic                  kill_req,
  input  logic                  clear_fault,
`ifdef POWER_MON_CH_MASK_EN
  input  logic [NUM_CH-1:0]     ch_mask,
`endif
  output logic [MUX_W-1:0]      mux,
  output logic [NUM_CH-1:0]     ch_status,
  output logic                  scan_done,
  output logic [SCAN_CNT_W-1:0] scan_count,
  output logic                  power,
  output logic                  fault,
  output logic [MUX_W-1:0]      fault_ch
);

  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int TW = cnt_w(TRIP_SCANS);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    TRIP_MAX    = TW'(TRIP_SCANS);
  localparam logic [MUX_W-1:0] CH_LAST     = MUX_W'(NUM_CH - 1);

  state_e                       state;
  logic [SW-1:0]                settle_cnt;
  logic                         sample_ok;
  logic [NUM_CH-1:0][TW-1:0]    fail_cnt, fail_upd;
  logic [NUM_CH-1:0]            mask_eff;
  logic                         f_start, f_done, f_ok;
  logic                         commit, wrap, trip, arm;

`ifdef POWER_MON_CH_MASK_EN
  assign mask_eff = ch_mask;
`else
  assign mask_eff = '0;
`endif

  assign f_start = enable && (state == SETTLE) && (settle_cnt == SETTLE_LAST);
  assign commit  = enable && (state == COMMIT);
  assign wrap    = commit && (mux == CH_LAST);

  pwr_mon_sample_filter #(.SAMPLES(SAMPLES)) u_filter (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .start   (f_start),
    .abort   (!enable),
    .done    (f_done),
    .ok      (f_ok)
  );

  // Fail counters after this cycle's commit. Trip fires only on the
  // transition into TRIP_MAX, so a saturated counter does not re-trip.
  always_comb begin
    fail_upd = fail_cnt;
    trip     = 1'b0;
    if (commit) begin
      if (sample_ok) begin
        fail_upd[mux] = '0;
      end else if (fail_cnt[mux] != TRIP_MAX) begin
        fail_upd[mux] = fail_cnt[mux] + 1'b1;
        trip = (fail_cnt[mux] == TRIP_MAX - 1'b1) && !mask_eff[mux];
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      if (mask_eff[i]) fail_upd[i] = '0;
  end

  // Arming looks at post-commit counters so a channel failing in the
  // wrap cycle itself still blocks power-up.
  assign arm = wrap && !fault && !kill_req && (fail_upd == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      sample_ok  <= 1'b0;
      fail_cnt   <= '0;
      mux        <= '0;
      ch_status  <= '0;
      scan_done  <= 1'b0;
      scan_count <= '0;
      power      <= 1'b0;
      fault      <= 1'b0;
      fault_ch   <= '0;
    end else begin
      scan_done <= 1'b0;

      if (!enable) begin
        state      <= IDLE;
        settle_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              state      <= SAMPLE;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          SAMPLE: begin
            if (f_done) begin
              sample_ok <= f_ok;
              state     <= COMMIT;
            end
          end
          COMMIT: begin
            ch_status[mux] <= sample_ok;
            if (mux == CH_LAST) begin
              mux        <= '0;
              scan_done  <= 1'b1;
              scan_count <= scan_count + 1'b1;
            end else begin
              mux <= mux + 1'b1;
            end
            state <= SETTLE;
          end
          default: state <= IDLE;
        endcase
      end

      fail_cnt <= clear_fault ? '0 : fail_upd;

      // Trip beats a same-cycle clear.
      if (trip) begin
        fault    <= 1'b1;
        fault_ch <= mux;
      end else if (clear_fault) begin
        fault    <= 1'b0;
        fault_ch <= '0;
      end

      if (kill_req || trip) power <= 1'b0;
      else if (arm)         power <= 1'b1;
    end
  end

endmodule
